pe_vec_pipe: RTL and testbench
==============================

PE_VEC_PIPE -- requirements
Module: pe_vec_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel datapath lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, lane operand/result width (8..32).
REQ-003 SHALL have parameter SATURATE, default 0; 1 = signed-saturating ADD/SUB.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk, rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  instruction/operands offered.
REQ-008 in_ready  output  1  block accepts on in_valid&in_ready at rising clk.
REQ-009 in_instr  input  32  {5'b0, class[26:20], func[19:15], rs1[14:10], rs2[9:5], rd[4:0]}.
REQ-010 in_a, in_b, in_c  input  LANES*DATA_W  packed lane operands, lane0 in LSBs.
REQ-011 in_src_rf  input  1  1 = a/b of every lane taken from rf[rs1]/rf[rs2], broadcast.
REQ-012 in_wb  input  1  write lane-0 result to rf[rd].
REQ-013 out_valid  output  1  result held until out_ready.
REQ-014 out_ready  input  1  consumer accepts.
REQ-015 out_result  output  LANES*DATA_W  packed lane results.
REQ-016 out_err  output  1  illegal class/func for this result.
REQ-017 rf_rd_addr  input  5  debug read address; rf_rd_data  output  DATA_W  combinational rf[rf_rd_addr].
REQ-018 op_count  output  16  count of results consumed (out_valid&out_ready), wraps 0xFFFF->0.

Function
REQ-019 SHALL implement a 2-stage pipeline: S1 = operand capture/decode register, S2 = result register; out_valid = S2 valid.
REQ-020 Latency SHALL be 2 clk edges from acceptance to out_valid with out_ready held high; throughput 1/cycle.
REQ-021 stall = out_valid & ~out_ready; on stall S1 and S2 SHALL hold; in_ready SHALL be ~stall & ~hazard.
REQ-022 hazard SHALL be 1 when in_valid & in_src_rf & S1 valid & S1.wb & S1.rd!=0 & (S1.rd==rs1 | S1.rd==rs2).
REQ-023 Class 1 (int): func 1 ADD, 2 SUB, 3 MUL (low DATA_W bits), 4 MAC a*b+c (low DATA_W bits), per lane.
REQ-024 Class 2 (act): func 11 RELU (signed a<0 -> 0 else a), func 12 MAX signed(a,b).
REQ-025 Class 16 (cmp): func 1 EQ, func 2 signed LT; result 1 or 0 zero-extended.
REQ-026 SATURATE=1: ADD/SUB overflow SHALL clamp to signed max/min of DATA_W; SATURATE=0 wraps.
REQ-027 Any other class/func SHALL produce all-zero result, out_err=1, and no register write.
REQ-028 RF SHALL be 32 x DATA_W; rf[0] reads 0 always, writes to it ignored.
REQ-029 Write-back of rf[rd] SHALL occur on the edge the instruction enters S2, before it is consumed.
REQ-030 in_src_rf operand reads SHALL sample rf at the acceptance edge (combinational read, no bypass).
REQ-031 Simultaneous S2-entry write and debug read of same address SHALL show old value until the edge.
REQ-032 in_valid while in_ready=0 SHALL not be captured; inputs may change freely.

Reset
REQ-033 rst high SHALL asynchronously clear S1/S2 valid, out_valid=0, out_result=0, out_err=0, op_count=0, all rf entries=0.
REQ-034 rst mid-operation SHALL discard in-flight instructions without any write-back; in_ready=1 on first edge after release.

Verification
REQ-035 LANES=4, ADD lanes a={10,15,100,-1}, b={20,25,30,1}, out_ready=1 -> out_valid 2 edges later, result {30,40,130,0}, op_count=1.
REQ-036 SATURATE=1, DATA_W=32, ADD 0x7FFFFFFF+1 -> 0x7FFFFFFF; SATURATE=0 -> 0x80000000.
REQ-037 ADD wb rd=5 (15+25), then in_src_rf SUB rs1=5 rs2=0 next cycle -> in_ready=0 one cycle (hazard), then result 40; rf_rd_data(5)=40.
REQ-038 RELU lanes {25,-25,0,-1} -> {25,0,0,0}; EQ 42,42 -> 1; LT -3,2 -> 1; class 3 -> out_err=1, result 0, no rf change.
REQ-039 out_ready=0 for 5 cycles with 3 instructions offered -> 2 accepted, in_ready=0, results held stable, delivered in order after release.
REQ-040 Assert rst while out_valid=1 and S1 holding wb rd=7 -> out_valid=0 immediately, rf[7]=0, op_count=0.

Source files
------------

// File: rtl/pe_vec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_vec_pipe : 2-stage LANES-wide vector PE with 32 x DATA_W register file  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pe_vec_pipe #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 32,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic [LANES*DATA_W-1:0] in_c,
  input  logic                    in_src_rf,
  input  logic                    in_wb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_result,
  output logic                    out_err,
  input  logic [4:0]              rf_rd_addr,
  output logic [DATA_W-1:0]       rf_rd_data,
  output logic [15:0]             op_count
);

  localparam int VW = LANES * DATA_W;
  localparam logic [6:0] CLS_INT = 7'd1;
  localparam logic [6:0] CLS_ACT = 7'd2;
  localparam logic [6:0] CLS_CMP = 7'd16;
  localparam logic [DATA_W-1:0] C_SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] C_SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic op_legal(input logic [6:0] cls, input logic [4:0] fn);
    case (cls)
      CLS_INT: return (fn >= 5'd1) && (fn <= 5'd4);
      CLS_ACT: return (fn == 5'd11) || (fn == 5'd12);
      CLS_CMP: return (fn == 5'd1) || (fn == 5'd2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_op(input logic [6:0] cls, input logic [4:0] fn,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] sum, dif, r;
    logic              ovf_add, ovf_sub;
    sum     = a + b;
    dif     = a - b;
    ovf_add = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    ovf_sub = (a[DATA_W-1] != b[DATA_W-1]) && (dif[DATA_W-1] != a[DATA_W-1]);
    r       = '0;
    case (cls)
      CLS_INT: begin
        case (fn)
          5'd1:    r = (SATURATE != 0 && ovf_add) ? (a[DATA_W-1] ? C_SMIN : C_SMAX) : sum;
          5'd2:    r = (SATURATE != 0 && ovf_sub) ? (a[DATA_W-1] ? C_SMIN : C_SMAX) : dif;
          5'd3:    r = a * b;
          5'd4:    r = a * b + c;
          default: r = '0;
        endcase
      end
      CLS_ACT: begin
        case (fn)
          5'd11:   r = a[DATA_W-1] ? '0 : a;
          5'd12:   r = ($signed(a) < $signed(b)) ? b : a;
          default: r = '0;
        endcase
      end
      CLS_CMP: begin
        case (fn)
          5'd1:    r = {{(DATA_W-1){1'b0}}, (a == b)};
          5'd2:    r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] rf_q [32];
  logic              s1_valid_q, s1_wb_q;
  logic [6:0]        s1_cls_q;
  logic [4:0]        s1_func_q, s1_rd_q;
  logic [VW-1:0]     s1_a_q, s1_b_q, s1_c_q, s1_a_d, s1_b_d;
  logic              out_valid_q, out_err_q;
  logic [VW-1:0]     out_result_q, res_d;
  logic [15:0]       op_count_q, op_count_d;
  logic              legal_d, stall, hazard, accept, rf_we;
  logic [4:0]        rs1, rs2;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^in_instr[31:27];
  assign rs1 = in_instr[14:10];
  assign rs2 = in_instr[9:5];

  // rf reads are taken combinationally at acceptance; there is no bypass, so an
  // older wb still sitting in S1 must block a dependent register-sourced op.
  assign stall  = out_valid_q & ~out_ready;
  assign hazard = in_valid & in_src_rf & s1_valid_q & s1_wb_q & (s1_rd_q != 5'd0) &
                  ((s1_rd_q == rs1) | (s1_rd_q == rs2));
  assign in_ready = ~stall & ~hazard;
  assign accept   = in_valid & in_ready;

  assign s1_a_d = in_src_rf ? {LANES{rf_q[rs1]}} : in_a;
  assign s1_b_d = in_src_rf ? {LANES{rf_q[rs2]}} : in_b;

  assign legal_d = op_legal(s1_cls_q, s1_func_q);
  always_comb begin
    res_d = '0;
    for (int l = 0; l < LANES; l++) begin
      res_d[l*DATA_W +: DATA_W] = lane_op(s1_cls_q, s1_func_q, s1_a_q[l*DATA_W +: DATA_W],
                                          s1_b_q[l*DATA_W +: DATA_W], s1_c_q[l*DATA_W +: DATA_W]);
    end
  end

  assign rf_we      = ~stall & s1_valid_q & s1_wb_q & legal_d & (s1_rd_q != 5'd0);
  assign op_count_d = op_count_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[s1_rd_q] <= res_d[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_wb_q      <= 1'b0;
      s1_cls_q     <= '0;
      s1_func_q    <= '0;
      s1_rd_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_c_q       <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_wb_q   <= in_wb;
          s1_cls_q  <= in_instr[26:20];
          s1_func_q <= in_instr[19:15];
          s1_rd_q   <= in_instr[4:0];
          s1_a_q    <= s1_a_d;
          s1_b_q    <= s1_b_d;
          s1_c_q    <= in_c;
        end
        out_valid_q  <= s1_valid_q;
        out_result_q <= res_d;
        out_err_q    <= s1_valid_q & ~legal_d;
      end
      if (out_valid_q && out_ready) op_count_q <= op_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign op_count   = op_count_q;
  assign rf_rd_data = (rf_rd_addr == 5'd0) ? '0 : rf_q[rf_rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_pe_vec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe_vec_pipe : directed table + sequence bench for pe_vec_pipe           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pe_vec_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_instr = '0;
  logic [127:0] in_a = '0, in_b = '0, in_c = '0;
  logic         in_src_rf = 1'b0, in_wb = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_result;
  logic         out_err;
  logic [4:0]   rf_rd_addr = '0;
  logic [31:0]  rf_rd_data;
  logic [15:0]  op_count;

  logic [127:0] sat_result;
  logic         sat_unused_ready, sat_unused_valid, sat_unused_err;
  logic [31:0]  sat_unused_rf;
  logic [15:0]  sat_unused_cnt;

  always #5 clk = ~clk;

  pe_vec_pipe #(.LANES(4), .DATA_W(32), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_src_rf(in_src_rf), .in_wb(in_wb),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .op_count(op_count));

  pe_vec_pipe #(.LANES(4), .DATA_W(32), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_unused_ready), .in_instr(in_instr),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_src_rf(in_src_rf), .in_wb(in_wb),
    .out_valid(sat_unused_valid), .out_ready(out_ready), .out_result(sat_result),
    .out_err(sat_unused_err), .rf_rd_addr(rf_rd_addr), .rf_rd_data(sat_unused_rf),
    .op_count(sat_unused_cnt));

  typedef struct {
    logic [6:0]   cls;
    logic [4:0]   fn;
    logic         wb;
    logic [4:0]   rd;
    logic [127:0] a, b, c, exp, exps;
    logic         err;
  } vec_t;

  vec_t vq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] L4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] ins(input logic [6:0] c, input logic [4:0] f,
                                      input logic [4:0] r1, input logic [4:0] r2,
                                      input logic [4:0] rd);
    return {5'b0, c, f, r1, r2, rd};
  endfunction

  task automatic add_vec(input logic [6:0] c, input logic [4:0] f, input logic wb,
                         input logic [4:0] rd, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] cc, input logic [127:0] e, input logic [127:0] es,
                         input logic err);
    vec_t v;
    v.cls = c; v.fn = f; v.wb = wb; v.rd = rd;
    v.a = a; v.b = b; v.c = cc; v.exp = e; v.exps = es; v.err = err;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [31:0] ins_w, input logic [127:0] a, input logic [127:0] b,
                       input logic wb, input logic src);
    in_instr = ins_w; in_a = a; in_b = b; in_c = '0; in_wb = wb; in_src_rf = src;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got;
    logic acc, stable_ok;

    add_vec(7'd1, 5'd1, 1'b1, 5'd3, L4(10, 15, 100, -1), L4(20, 25, 30, 1), '0,
            L4(30, 40, 130, 0), L4(30, 40, 130, 0), 1'b0);
    add_vec(7'd1, 5'd1, 1'b0, 5'd0, L4(32'h7FFFFFFF, 0, 32'h80000000, 5), L4(1, 0, -1, 3), '0,
            L4(32'h80000000, 0, 32'h7FFFFFFF, 8), L4(32'h7FFFFFFF, 0, 32'h80000000, 8), 1'b0);
    add_vec(7'd1, 5'd2, 1'b0, 5'd0, L4(5, 0, 32'h80000000, 32'h7FFFFFFF), L4(3, 1, 1, -1), '0,
            L4(2, -1, 32'h7FFFFFFF, 32'h80000000), L4(2, -1, 32'h80000000, 32'h7FFFFFFF), 1'b0);
    add_vec(7'd1, 5'd3, 1'b0, 5'd0, L4(3, -2, 32'h10000, 7), L4(4, 5, 32'h10000, 0), '0,
            L4(12, -10, 0, 0), L4(12, -10, 0, 0), 1'b0);
    add_vec(7'd1, 5'd4, 1'b0, 5'd0, L4(2, 3, -1, 0), L4(3, 4, 1, 9), L4(1, -12, 5, 6),
            L4(7, 0, 4, 6), L4(7, 0, 4, 6), 1'b0);
    add_vec(7'd2, 5'd11, 1'b0, 5'd0, L4(25, -25, 0, -1), '0, '0,
            L4(25, 0, 0, 0), L4(25, 0, 0, 0), 1'b0);
    add_vec(7'd2, 5'd12, 1'b0, 5'd0, L4(1, -5, -1, 100), L4(2, -7, 0, 100), '0,
            L4(2, -5, 0, 100), L4(2, -5, 0, 100), 1'b0);
    add_vec(7'd16, 5'd1, 1'b0, 5'd0, L4(42, 1, 0, -1), L4(42, 2, 0, -1), '0,
            L4(1, 0, 1, 1), L4(1, 0, 1, 1), 1'b0);
    add_vec(7'd16, 5'd2, 1'b0, 5'd0, L4(-3, 2, 5, -1), L4(2, -3, 5, 0), '0,
            L4(1, 0, 0, 1), L4(1, 0, 0, 1), 1'b0);
    add_vec(7'd3, 5'd1, 1'b1, 5'd9, L4(1, 2, 3, 4), L4(5, 6, 7, 8), '0, '0, '0, 1'b1);
    add_vec(7'd1, 5'd5, 1'b1, 5'd9, L4(1, 2, 3, 4), L4(5, 6, 7, 8), '0, '0, '0, 1'b1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_op_count", op_count, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    chk("rst_in_ready", in_ready, 1);

    // table-driven single-instruction vectors
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(ins(vq[i].cls, vq[i].fn, 5'd0, 5'd0, vq[i].rd), vq[i].a, vq[i].b, vq[i].wb, 1'b0);
      in_c = vq[i].c;
      @(posedge clk) #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), out_valid, 0);
      @(posedge clk) #1;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_result", i), out_result, vq[i].exp);
      chk($sformatf("v%0d_sat_result", i), sat_result, vq[i].exps);
      chk($sformatf("v%0d_err", i), out_err, vq[i].err);
      @(posedge clk) #1;
      chk($sformatf("v%0d_op_count", i), op_count, i + 1);
    end
    rf_rd_addr = 5'd3; #1;
    chk("rf3_after_add", rf_rd_data, 30);
    rf_rd_addr = 5'd9; #1;
    chk("rf9_illegal_nowrite", rf_rd_data, 0);

    // RAW hazard on in_src_rf read of an rd still in S1
    @(negedge clk);
    drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd5), L4(15, 0, 0, 0), L4(25, 0, 0, 0), 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(ins(7'd1, 5'd2, 5'd5, 5'd0, 5'd0), '0, '0, 1'b0, 1'b1);
    rf_rd_addr = 5'd5;
    #1;
    chk("hazard_in_ready", in_ready, 0);
    chk("rf5_before_wb_edge", rf_rd_data, 0);
    @(posedge clk) #1;
    chk("hazard_cleared", in_ready, 1);
    chk("rf5_after_wb", rf_rd_data, 40);
    chk("hazard_add_result", out_result, L4(40, 0, 0, 0));
    @(posedge clk) #1;
    in_valid = 1'b0;
    @(posedge clk) #1;
    chk("hazard_sub_valid", out_valid, 1);
    chk("hazard_sub_result", out_result, L4(40, 40, 40, 40));
    @(posedge clk);

    // backpressure: 5 stalled cycles with 3 instructions offered
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    stable_ok = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd0), L4(k + 1, 0, 0, 0), '0, 1'b0, 1'b0);
      #1;
      acc = in_ready;
      if (out_valid && out_result[31:0] != 32'd1) stable_ok = 1'b0;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd0), L4(k + 1, 0, 0, 0), '0, 1'b0, 1'b0);
    #1;
    chk("bp_accepted", k, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_held_result", out_result, L4(1, 0, 0, 0));
    chk("bp_stable", stable_ok, 1);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (k < 3) drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd0), L4(k + 1, 0, 0, 0), '0, 1'b0, 1'b0);
      else in_valid = 1'b0;
      #1;
      acc = in_valid & in_ready;
      if (out_valid) begin
        chk($sformatf("bp_order%0d", got), out_result[31:0], got + 1);
        got++;
      end
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    chk("bp_drain_count", got, 3);

    // reset with a result held and a wb to rd=7 waiting in S1
    out_ready = 1'b0;
    drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd0), L4(1, 0, 0, 0), '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(ins(7'd1, 5'd1, 5'd0, 5'd0, 5'd7), L4(9, 0, 0, 0), '0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst2_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_op_count", op_count, 0);
    chk("rst2_out_result", out_result, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk) #1;
    chk("rst2_in_ready", in_ready, 1);
    rf_rd_addr = 5'd7; #1;
    chk("rst2_rf7", rf_rd_data, 0);
    rf_rd_addr = 5'd5; #1;
    chk("rst2_rf5_cleared", rf_rd_data, 0);
    chk("rst2_no_output", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
